// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: opcodes, access sizes, FSM states
// and small decode helpers used by the top level and the load extender.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Bus size code for a load/store opcode; anything unrecognised is a word access.
  function automatic logic [1:0] access_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: access_size = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: access_size = SIZE_HALF;
      default:              access_size = SIZE_WORD;
    endcase
  endfunction

  // Replicate store data across every lane so the slave can pick by address.
  function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   store_lanes = {4{d[7:0]}};
      OP_SH:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // True when the access does not sit on its natural boundary.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] addr_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: misaligned = addr_lo[0];
      OP_LW, OP_SW:         misaligned = (addr_lo != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Load data alignment: picks the addressed byte/half lane out of the bus word
// and sign- or zero-extends it according to the load opcode.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  opcode,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension; word loads pass the bus word through.
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    case (opcode)
      OP_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  value = {24'd0, byte_sel};
      OP_LH:   value = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  value = {16'd0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage of the five-stage pipeline. Takes one instruction per
// valid/allowin handshake, runs loads/stores over an SRAM-like req/addr_ok/data_ok
// bus and presents writeback operands. Define MEM_ADDR_EXC_EN to trap misaligned
// accesses (no bus request, adel/ades outputs raised alongside mem_valid).
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  output logic              mem_allowin,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic [4:0]        write_reg_in,
  input  logic              reg_write_in,
  input  logic [31:0]       inst_in,
  input  logic [31:0]       pc_in,
  input  logic              wb_allowin,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              mem_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_reg,
  output logic              wb_we,
  output logic [31:0]       pc_out,
  output logic              mem_stall
`ifdef MEM_ADDR_EXC_EN
  ,
  output logic              adel,
  output logic              ades
`endif
);

  state_t      state, state_next;
  logic [31:0] addr_r, sdata_r, pc_r, rdata_r, load_value;
  logic [5:0]  opcode_r;
  logic [4:0]  write_reg_r;
  logic        mem_read_r, mem_write_r, mem_to_reg_r, reg_write_r;
  logic        exc_load_r, exc_store_r;
  logic        accept, misaligned_in, start_bus, in_req;

  assign mem_allowin = (state == ST_IDLE) || ((state == ST_DONE) && wb_allowin);
  assign accept      = exe_valid && mem_allowin;
  assign start_bus   = (mem_read_in || mem_write_in) && !misaligned_in;

  // Misalignment trap is only present when the exception feature is built in.
  always_comb begin
    misaligned_in = 1'b0;
`ifdef MEM_ADDR_EXC_EN
    misaligned_in = (mem_read_in || mem_write_in) && misaligned(inst_in[31:26], alu_result[1:0]);
`endif
  end

  // State register; reset abandons any bus transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a finishing DONE may chain straight into the next instruction.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)       state_next = start_bus ? ST_REQ : ST_DONE;
      ST_REQ:  if (data_addr_ok) state_next = ST_WAIT;
      ST_WAIT: if (data_data_ok) state_next = ST_DONE;
      ST_DONE: if (wb_allowin)   state_next = accept ? (start_bus ? ST_REQ : ST_DONE) : ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Instruction capture on handshake and load data capture when the bus returns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r       <= '0;
      sdata_r      <= '0;
      pc_r         <= '0;
      rdata_r      <= '0;
      opcode_r     <= '0;
      write_reg_r  <= '0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      reg_write_r  <= 1'b0;
      exc_load_r   <= 1'b0;
      exc_store_r  <= 1'b0;
    end else begin
      if (accept) begin
        addr_r       <= alu_result;
        sdata_r      <= mem_data_in;
        pc_r         <= pc_in;
        opcode_r     <= inst_in[31:26];
        write_reg_r  <= write_reg_in;
        mem_read_r   <= mem_read_in;
        mem_write_r  <= mem_write_in;
        mem_to_reg_r <= mem_to_reg_in;
        reg_write_r  <= reg_write_in;
        exc_load_r   <= mem_read_in && misaligned_in;
        exc_store_r  <= mem_write_in && misaligned_in;
      end
      if ((state == ST_WAIT) && data_data_ok)
        rdata_r <= data_rdata;
    end
  end

  mem_load_ext u_load_ext (
    .rdata   (rdata_r),
    .addr_lo (addr_r[1:0]),
    .opcode  (opcode_r),
    .value   (load_value)
  );

  // Bus fields are driven only while requesting so the bus reads idle otherwise.
  assign in_req     = (state == ST_REQ);
  assign data_req   = in_req;
  assign data_wr    = in_req && mem_write_r;
  assign data_size  = in_req ? access_size(opcode_r) : SIZE_BYTE;
  assign data_addr  = in_req ? addr_r[ADDR_W-1:0] : '0;
  assign data_wdata = in_req ? store_lanes(opcode_r, sdata_r) : '0;

  assign mem_valid = (state == ST_DONE);
  assign mem_stall = (state == ST_REQ) || (state == ST_WAIT) || ((state == ST_DONE) && !wb_allowin);
  assign wb_data   = mem_to_reg_r ? load_value : addr_r;
  assign wb_reg    = write_reg_r;
  assign wb_we     = reg_write_r && !mem_write_r && !exc_load_r && !exc_store_r;
  assign pc_out    = pc_r;

`ifdef MEM_ADDR_EXC_EN
  assign adel = mem_valid && exc_load_r;
  assign ades = mem_valid && exc_store_r;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// loads/stores/ALU ops checked against an arithmetic reference model.
module tb_mem_access;

  localparam logic [5:0] T_LB  = 6'b100000;
  localparam logic [5:0] T_LH  = 6'b100001;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_LBU = 6'b100100;
  localparam logic [5:0] T_LHU = 6'b100101;
  localparam logic [5:0] T_SB  = 6'b101000;
  localparam logic [5:0] T_SH  = 6'b101001;
  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_ADD = 6'b000000;

  logic        clk, rst, exe_valid, mem_allowin;
  logic [31:0] alu_result, mem_data_in, inst_in, pc_in;
  logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic [4:0]  write_reg_in;
  logic        wb_allowin, data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_valid, wb_we, mem_stall;
  logic [31:0] wb_data, pc_out;
  logic [4:0]  wb_reg;
`ifdef MEM_ADDR_EXC_EN
  logic        adel, ades;
`endif

  int testCount = 0;
  int failCount = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .mem_allowin(mem_allowin),
    .alu_result(alu_result), .mem_data_in(mem_data_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in), .write_reg_in(write_reg_in),
    .reg_write_in(reg_write_in), .inst_in(inst_in), .pc_in(pc_in), .wb_allowin(wb_allowin),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_valid(mem_valid), .wb_data(wb_data), .wb_reg(wb_reg),
    .wb_we(wb_we), .pc_out(pc_out), .mem_stall(mem_stall)
`ifdef MEM_ADDR_EXC_EN
    , .adel(adel), .ades(ades)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the run stalls somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit isLoad(input logic [5:0] op);
    return op == T_LB || op == T_LH || op == T_LW || op == T_LBU || op == T_LHU;
  endfunction

  function automatic bit isStore(input logic [5:0] op);
    return op == T_SB || op == T_SH || op == T_SW;
  endfunction

  // Access width in bytes.
  function automatic int refBytes(input logic [5:0] op);
    if (op == T_LB || op == T_LBU || op == T_SB) return 1;
    if (op == T_LH || op == T_LHU || op == T_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] refSizeCode(input logic [5:0] op);
    int n;
    n = refBytes(op);
    return (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2;
  endfunction

  function automatic logic [31:0] refWdata(input logic [5:0] op, input logic [31:0] d);
    int n;
    n = refBytes(op);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] refLoad(input logic [5:0] op, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    logic [31:0] v;
    int lane;
    lane = int'(addr % 4);
    if (refBytes(op) == 1) begin
      v = (rdata >> (8 * lane)) & 32'hFF;
      if (op == T_LB && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (refBytes(op) == 2) begin
      v = (rdata >> (16 * (lane / 2))) & 32'hFFFF;
      if (op == T_LH && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic driveInstr(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] rd, input logic regWr, input logic [31:0] pc);
    logic [31:0] low;
    low           = $urandom;
    exe_valid     = 1'b1;
    alu_result    = addr;
    mem_data_in   = sdata;
    mem_read_in   = isLoad(op);
    mem_write_in  = isStore(op);
    mem_to_reg_in = isLoad(op);
    write_reg_in  = rd;
    reg_write_in  = regWr;
    inst_in       = {op, low[25:0]};
    pc_in         = pc;
  endtask

  // One instruction end to end; returns at the falling edge where it sits in DONE.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int addrDelay, input int dataDelay,
                               input bit stallWb, input bit expectReq);
    logic [4:0]  rd;
    logic [31:0] pc, expData;
    logic        regWr, exc, mem;
    rd    = 5'($urandom);
    pc    = $urandom & 32'hFFFFFFFC;
    regWr = 1'($urandom);
    mem   = isLoad(op) || isStore(op);
    exc   = mem && !expectReq;
    @(negedge clk);
    checkOutput("allowin_idle", 32'(mem_allowin), 32'd1);
    driveInstr(op, addr, sdata, rd, regWr, pc);
    @(posedge clk);
    @(negedge clk);
    exe_valid = 1'b0;
    if (mem && expectReq) begin
      for (int i = 0; i <= addrDelay; i++) begin
        checkOutput("req_held", 32'(data_req), 32'd1);
        checkOutput("req_addr", data_addr, addr);
        checkOutput("req_size", 32'(data_size), refSizeCode(op));
        checkOutput("req_wr", 32'(data_wr), 32'(isStore(op)));
        if (isStore(op)) checkOutput("req_wdata", data_wdata, refWdata(op, sdata));
        checkOutput("req_valid", 32'(mem_valid), 32'd0);
        if (i < addrDelay) begin
          data_data_ok = (i == 0);
          data_rdata   = 32'hBAD0BAD0;
          @(posedge clk);
          @(negedge clk);
          data_data_ok = 1'b0;
        end
      end
      data_addr_ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_addr_ok = 1'b0;
      checkOutput("wait_noreq", 32'(data_req), 32'd0);
      checkOutput("wait_stall", 32'(mem_stall), 32'd1);
      for (int i = 0; i < dataDelay; i++) begin
        checkOutput("wait_valid", 32'(mem_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
      end
      data_data_ok = 1'b1;
      data_rdata   = rdata;
      if (stallWb) wb_allowin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      data_data_ok = 1'b0;
      data_rdata   = $urandom;
    end else begin
      checkOutput("direct_noreq", 32'(data_req), 32'd0);
    end
    expData = isLoad(op) ? refLoad(op, addr, rdata) : addr;
    checkOutput("done_valid", 32'(mem_valid), 32'd1);
    if (!exc) checkOutput("done_wb_data", wb_data, expData);
    checkOutput("done_wb_we", 32'(wb_we), 32'(regWr && !isStore(op) && !exc));
    checkOutput("done_wb_reg", 32'(wb_reg), 32'(rd));
    checkOutput("done_pc", pc_out, pc);
    checkOutput("done_stall", 32'(mem_stall), 32'(stallWb));
`ifdef MEM_ADDR_EXC_EN
    checkOutput("done_adel", 32'(adel), 32'(exc && isLoad(op)));
    checkOutput("done_ades", 32'(ades), 32'(exc && isStore(op)));
`endif
  endtask

  initial begin
    logic [5:0]  ops [9];
    logic [5:0]  op;
    logic [31:0] addr;
    ops = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW, T_ADD};

    rst = 1'b1; exe_valid = 1'b0; alu_result = '0; mem_data_in = '0; mem_read_in = 1'b0;
    mem_write_in = 1'b0; mem_to_reg_in = 1'b0; write_reg_in = '0; reg_write_in = 1'b0;
    inst_in = '0; pc_in = '0; wb_allowin = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_allowin", 32'(mem_allowin), 32'd1);
    checkOutput("rst_req", 32'(data_req), 32'd0);
    checkOutput("rst_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_size", 32'(data_size), 32'd0);
    rst = 1'b0;

    // Non-memory pass-through.
    applyStimulus(T_ADD, 32'h12345678, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1);

    // Byte loads with sign and zero extension from the top lane.
    applyStimulus(T_LB,  32'h00000103, 32'h0, 32'h80FFFFFF, 0, 1, 1'b0, 1'b1);
    applyStimulus(T_LBU, 32'h00000103, 32'h0, 32'h80FFFFFF, 1, 0, 1'b0, 1'b1);

    // Halfword store with a slow address handshake.
    applyStimulus(T_SH, 32'h00002002, 32'hDEADBEEF, 32'h0, 3, 1, 1'b0, 1'b1);

    // Back-pressure on a completed word load, then same-cycle hand-over.
    applyStimulus(T_LW, 32'h00003000, 32'h0, 32'h13579BDF, 0, 2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_valid", 32'(mem_valid), 32'd1);
      checkOutput("bp_data", wb_data, 32'h13579BDF);
      checkOutput("bp_allowin", 32'(mem_allowin), 32'd0);
    end
    wb_allowin = 1'b1;
    driveInstr(T_ADD, 32'hCAFEF00D, 32'h0, 5'd7, 1'b1, 32'h00400010);
    #1;
    checkOutput("bp_allowin_rise", 32'(mem_allowin), 32'd1);
    @(posedge clk);
    @(negedge clk);
    exe_valid = 1'b0;
    checkOutput("bp_next_valid", 32'(mem_valid), 32'd1);
    checkOutput("bp_next_data", wb_data, 32'hCAFEF00D);
    checkOutput("bp_next_noreq", 32'(data_req), 32'd0);

    // Reset while waiting for read data; a late data_ok must be ignored.
    @(negedge clk);
    driveInstr(T_LW, 32'h00004000, 32'h0, 5'd3, 1'b1, 32'h00400020);
    @(posedge clk);
    @(negedge clk);
    exe_valid = 1'b0;
    data_addr_ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_addr_ok = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_req", 32'(data_req), 32'd0);
    checkOutput("midrst_stall", 32'(mem_stall), 32'd0);
    checkOutput("midrst_allowin", 32'(mem_allowin), 32'd1);
    checkOutput("midrst_pc", pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    data_data_ok = 1'b0;
    checkOutput("stray_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    checkOutput("stray_valid2", 32'(mem_valid), 32'd0);
    checkOutput("stray_allowin", 32'(mem_allowin), 32'd1);

    // Misaligned word load: trapped when the feature is built in, issued otherwise.
`ifdef MEM_ADDR_EXC_EN
    applyStimulus(T_LW, 32'h00005002, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
    applyStimulus(T_SH, 32'h00005001, 32'h1234, 32'h0, 0, 0, 1'b0, 1'b0);
`else
    applyStimulus(T_LW, 32'h00005002, 32'h0, 32'hA5A5C3C3, 0, 0, 1'b0, 1'b1);
`endif

    // Randomized mix against the reference model.
    for (int n = 0; n < 30; n++) begin
      op   = ops[$urandom_range(0, 8)];
      addr = $urandom;
`ifdef MEM_ADDR_EXC_EN
      addr = addr & ~(32'(refBytes(op)) - 32'd1);
`endif
      applyStimulus(op, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    1'b0, 1'b1);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
